// File: rtl/vga_seq_pkg.sv
// vga_seq_pkg: screen mode encodings, default hold times and display saturation limit
package vga_seq_pkg;
    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_COIN  = 2'd1;
    localparam logic [1:0] MODE_VEND  = 2'd2;
    localparam logic [1:0] MODE_ERROR = 2'd3;

    localparam int DEF_COIN_FRAMES  = 30;
    localparam int DEF_VEND_FRAMES  = 120;
    localparam int DEF_ERROR_FRAMES = 90;
    localparam int DEF_FLASH_FRAMES = 15;

    localparam logic [7:0] DISP_MAX = 8'd99;

    function automatic logic [7:0] sat_disp(input logic [7:0] v);
        return (v > DISP_MAX) ? DISP_MAX : v;
    endfunction
endpackage

// File: rtl/vga_screen_sequencer_frame_timer.sv
// frame_timer: loadable down-counter that steps on frame ticks and stops at zero
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         tick,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] count;

    // load has priority over a tick; the count holds at zero instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (tick && count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);
endmodule

// File: rtl/vga_screen_sequencer.sv
// vga_screen_sequencer: frame-timed screen selection with request priority; VGA_SEQ_FLASH_EN enables error flashing
module vga_screen_sequencer
    import vga_seq_pkg::*;
#(
    parameter int COIN_FRAMES  = DEF_COIN_FRAMES,
    parameter int VEND_FRAMES  = DEF_VEND_FRAMES,
    parameter int ERROR_FRAMES = DEF_ERROR_FRAMES,
    parameter int FLASH_FRAMES = DEF_FLASH_FRAMES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       req_coin,
    input  logic       req_vend,
    input  logic       req_error,
    input  logic [7:0] credit,
    input  logic [7:0] price,
    output logic [1:0] screen_mode,
    output logic       ack_coin,
    output logic       ack_vend,
    output logic       ack_error,
    output logic [7:0] disp_credit,
    output logic [7:0] disp_price,
    output logic       flash_on,
    output logic       busy
);
    localparam int MAX_FRAMES = (COIN_FRAMES > VEND_FRAMES)
        ? ((COIN_FRAMES > ERROR_FRAMES) ? COIN_FRAMES : ERROR_FRAMES)
        : ((VEND_FRAMES > ERROR_FRAMES) ? VEND_FRAMES : ERROR_FRAMES);
    localparam int CW = $clog2(MAX_FRAMES + 1);
    localparam logic [CW-1:0] COIN_LOAD  = CW'(COIN_FRAMES - 1);
    localparam logic [CW-1:0] VEND_LOAD  = CW'(VEND_FRAMES - 1);
    localparam logic [CW-1:0] ERROR_LOAD = CW'(ERROR_FRAMES - 1);

    // bit order everywhere: {error, vend, coin}
    logic [2:0]    pend, clr, grant_q, ack_q;
    logic [1:0]    hp_mode, mode_next;
    logic [CW-1:0] load_val;
    logic          any_pend, grant, cnt_zero;

    assign any_pend = |pend;
    assign hp_mode  = pend[2] ? MODE_ERROR : pend[1] ? MODE_VEND : pend[0] ? MODE_COIN : MODE_IDLE;
    // encodings are priority-ordered, so >= covers idle entry, preemption and same-mode reload
    assign grant    = frame_tick && any_pend && (hp_mode >= screen_mode || cnt_zero);
    assign clr      = grant ? {hp_mode == MODE_ERROR, hp_mode == MODE_VEND, hp_mode == MODE_COIN} : 3'b000;
    assign load_val = (hp_mode == MODE_ERROR) ? ERROR_LOAD : (hp_mode == MODE_VEND) ? VEND_LOAD : COIN_LOAD;
    assign mode_next = grant ? hp_mode : (frame_tick && cnt_zero) ? MODE_IDLE : screen_mode;

    frame_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (grant),
        .tick     (frame_tick),
        .load_val (load_val),
        .zero     (cnt_zero)
    );

    // pending bits (a new request beats a same-cycle grant), mode, two-stage ack pipe, frame-stable display
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= 3'b000;
            screen_mode <= MODE_IDLE;
            grant_q     <= 3'b000;
            ack_q       <= 3'b000;
            disp_credit <= 8'd0;
            disp_price  <= 8'd0;
        end else begin
            pend        <= {req_error, req_vend, req_coin} | (pend & ~clr);
            screen_mode <= mode_next;
            grant_q     <= clr;
            ack_q       <= grant_q;
            if (frame_tick) begin
                disp_credit <= sat_disp(credit);
                disp_price  <= sat_disp(price);
            end
        end
    end

    assign ack_coin  = ack_q[0];
    assign ack_vend  = ack_q[1];
    assign ack_error = ack_q[2];
    assign busy      = (screen_mode != MODE_IDLE) || any_pend;

`ifdef VGA_SEQ_FLASH_EN
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_FRAMES - 1);

    logic err_entry, flash_zero;

    assign err_entry = grant && (hp_mode == MODE_ERROR);

    frame_timer #(.W(FW)) u_flash (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (frame_tick && (err_entry || flash_zero)),
        .tick     (frame_tick),
        .load_val (FLASH_LOAD),
        .zero     (flash_zero)
    );

    // flash phase restarts lit on every error grant and is held lit outside the error screen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flash_on <= 1'b1;
        else if (mode_next != MODE_ERROR || err_entry)
            flash_on <= 1'b1;
        else if (frame_tick && flash_zero)
            flash_on <= ~flash_on;
    end
`else
    assign flash_on = 1'b1;
`endif
endmodule

// File: tb/tb_vga_screen_sequencer.sv
// tb_vga_screen_sequencer: scenario tasks with an ack scoreboard for vga_screen_sequencer
module tb_vga_screen_sequencer;
    import vga_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       req_coin = 1'b0;
    logic       req_vend = 1'b0;
    logic       req_error = 1'b0;
    logic [7:0] credit = 8'd0;
    logic [7:0] price = 8'd0;
    logic [1:0] screen_mode;
    logic       ack_coin, ack_vend, ack_error;
    logic [7:0] disp_credit, disp_price;
    logic       flash_on, busy;

    int vectors = 0;
    int miscompares = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    vga_screen_sequencer #(
        .COIN_FRAMES  (3),
        .VEND_FRAMES  (4),
        .ERROR_FRAMES (5),
        .FLASH_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .req_coin    (req_coin),
        .req_vend    (req_vend),
        .req_error   (req_error),
        .credit      (credit),
        .price       (price),
        .screen_mode (screen_mode),
        .ack_coin    (ack_coin),
        .ack_vend    (ack_vend),
        .ack_error   (ack_error),
        .disp_credit (disp_credit),
        .disp_price  (disp_price),
        .flash_on    (flash_on),
        .busy        (busy)
    );

    // one clock with the given tick/request inputs; any ack seen is popped against the scoreboard
    task automatic cyc(input logic t, input logic rc, input logic rv, input logic re);
        logic [1:0] e_mode;
        logic [2:0] got_v, exp_v;
        frame_tick = t; req_coin = rc; req_vend = rv; req_error = re;
        @(posedge clk); #1;
        frame_tick = 1'b0; req_coin = 1'b0; req_vend = 1'b0; req_error = 1'b0;
        got_v = {ack_error, ack_vend, ack_coin};
        if (got_v != 3'b000) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL ack_unexpected: acks {err,vend,coin}=%b, required none", got_v);
            end else begin
                e_mode = exp_q.pop_front();
                exp_v = 3'b001 << (e_mode - 2'd1);
                if (got_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL ack_order: acks {err,vend,coin}=%b, required %b", got_v, exp_v);
                end
            end
        end
    endtask

    task automatic frame();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({screen_mode, ack_error, ack_vend, ack_coin, disp_credit, disp_price, flash_on, busy} !== {2'd0, 3'b000, 8'd0, 8'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: mode=%0d acks=%b credit=%0d price=%0d flash=%b busy=%b, required 0 000 0 0 1 0",
                     screen_mode, {ack_error, ack_vend, ack_coin}, disp_credit, disp_price, flash_on, busy);
        end
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_coin();
        exp_q.push_back(MODE_COIN);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (screen_mode !== MODE_IDLE || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL coin_pending: mode=%0d busy=%b, required 0 1", screen_mode, busy);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (screen_mode !== MODE_COIN || ack_coin !== 1'b0) begin
            miscompares++;
            $display("FAIL coin_entry: mode=%0d ack_coin=%b, required 1 0", screen_mode, ack_coin);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (ack_coin !== 1'b1) begin
            miscompares++;
            $display("FAIL coin_ack_timing: ack_coin=%b, required 1", ack_coin);
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            frame();
            vectors++;
            if (screen_mode !== ((k < 4) ? MODE_COIN : MODE_IDLE)) begin
                miscompares++;
                $display("FAIL coin_hold tick%0d: mode=%0d, required %0d", k, screen_mode, (k < 4) ? MODE_COIN : MODE_IDLE);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL coin_busy_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] e;
        exp_q.push_back(MODE_ERROR);
        exp_q.push_back(MODE_COIN);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            frame();
            e = (k <= 5) ? MODE_ERROR : (k <= 8) ? MODE_COIN : MODE_IDLE;
            vectors++;
            if (screen_mode !== e) begin
                miscompares++;
                $display("FAIL simul tick%0d: mode=%0d, required %0d", k, screen_mode, e);
            end
        end
    endtask

    task automatic test_flash();
        logic [5:0] fl;
        logic [1:0] e;
`ifdef VGA_SEQ_FLASH_EN
        fl = 6'b110011;
`else
        fl = 6'b111111;
`endif
        exp_q.push_back(MODE_ERROR);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            e = (k <= 5) ? MODE_ERROR : MODE_IDLE;
            vectors++;
            if (flash_on !== fl[k-1] || screen_mode !== e) begin
                miscompares++;
                $display("FAIL flash tick%0d: flash=%b mode=%0d, required %b %0d", k, flash_on, screen_mode, fl[k-1], e);
            end
            repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_preempt();
        exp_q.push_back(MODE_COIN);
        exp_q.push_back(MODE_VEND);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        frame();
        vectors++;
        if (screen_mode !== MODE_COIN) begin
            miscompares++;
            $display("FAIL preempt_coin: mode=%0d, required 1", screen_mode);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        frame();
        vectors++;
        if (screen_mode !== MODE_VEND) begin
            miscompares++;
            $display("FAIL preempt_vend: mode=%0d, required 2", screen_mode);
        end
        for (int k = 2; k <= 5; k++) begin
            frame();
            vectors++;
            if (screen_mode !== ((k < 5) ? MODE_VEND : MODE_IDLE)) begin
                miscompares++;
                $display("FAIL preempt_no_resume tick%0d: mode=%0d, required %0d", k, screen_mode, (k < 5) ? MODE_VEND : MODE_IDLE);
            end
        end
    endtask

    task automatic test_lower_equal();
        logic [1:0] e;
        exp_q.push_back(MODE_VEND);
        exp_q.push_back(MODE_VEND);
        exp_q.push_back(MODE_COIN);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        frame();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        frame();
        vectors++;
        if (screen_mode !== MODE_VEND || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL lower_stays_pending: mode=%0d busy=%b, required 2 1", screen_mode, busy);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        frame();
        for (int k = 1; k <= 7; k++) begin
            frame();
            e = (k <= 3) ? MODE_VEND : (k <= 6) ? MODE_COIN : MODE_IDLE;
            vectors++;
            if (screen_mode !== e) begin
                miscompares++;
                $display("FAIL equal_reload tick%0d: mode=%0d, required %0d", k, screen_mode, e);
            end
        end
    endtask

    task automatic test_set_wins();
        exp_q.push_back(MODE_COIN);
        exp_q.push_back(MODE_COIN);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (screen_mode !== MODE_COIN || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL set_wins_entry: mode=%0d busy=%b, required 1 1", screen_mode, busy);
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        frame();
        for (int k = 1; k <= 3; k++) begin
            frame();
            vectors++;
            if (screen_mode !== ((k < 3) ? MODE_COIN : MODE_IDLE)) begin
                miscompares++;
                $display("FAIL set_wins_reload tick%0d: mode=%0d, required %0d", k, screen_mode, (k < 3) ? MODE_COIN : MODE_IDLE);
            end
        end
    endtask

    task automatic test_saturation();
        credit = 8'd5; price = 8'd7;
        frame();
        credit = 8'd150; price = 8'd255;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (disp_credit !== 8'd5 || disp_price !== 8'd7) begin
            miscompares++;
            $display("FAIL frame_stable: credit=%0d price=%0d, required 5 7", disp_credit, disp_price);
        end
        frame();
        vectors++;
        if (disp_credit !== 8'd99 || disp_price !== 8'd99) begin
            miscompares++;
            $display("FAIL saturate: credit=%0d price=%0d, required 99 99", disp_credit, disp_price);
        end
        credit = 8'd99; price = 8'd98;
        frame();
        vectors++;
        if (disp_credit !== 8'd99 || disp_price !== 8'd98) begin
            miscompares++;
            $display("FAIL sat_boundary: credit=%0d price=%0d, required 99 98", disp_credit, disp_price);
        end
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(MODE_VEND);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        frame();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({screen_mode, ack_error, ack_vend, ack_coin, disp_credit, disp_price, flash_on, busy} !== {2'd0, 3'b000, 8'd0, 8'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid: mode=%0d acks=%b credit=%0d price=%0d flash=%b busy=%b, required 0 000 0 0 1 0",
                     screen_mode, {ack_error, ack_vend, ack_coin}, disp_credit, disp_price, flash_on, busy);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            frame();
            vectors++;
            if (screen_mode !== MODE_IDLE || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_release tick%0d: mode=%0d busy=%b, required 0 0", k, screen_mode, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_coin();
        test_simultaneous();
        test_flash();
        test_preempt();
        test_lower_equal();
        test_set_wins();
        test_saturation();
        test_reset_mid();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_acks: %0d outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vga_screen_sequencer.md
VGA_SCREEN_SEQUENCER -- requirements
Module: vga_screen_sequencer

Interface
REQ-001 SHALL have parameter COIN_FRAMES, default 30, hold time in frames for the coin-accepted screen.
REQ-002 SHALL have parameter VEND_FRAMES, default 120, hold time in frames for the vend screen.
REQ-003 SHALL have parameter ERROR_FRAMES, default 90, hold time in frames for the error screen.
REQ-004 SHALL have parameter FLASH_FRAMES, default 15, frames per error-flash half-period.
REQ-005 SHALL have ports:
- clk  in  1  single system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_tick  in  1  one-cycle pulse at the start of each frame.
- req_coin  in  1  one-cycle request for the coin screen.
- req_vend  in  1  one-cycle request for the vend screen.
- req_error  in  1  one-cycle request for the error screen.
- credit  in  8  live credit.
- price  in  8  live price.
- screen_mode  out  2  IDLE=0, COIN=1, VEND=2, ERROR=3.
- ack_coin, ack_vend, ack_error  out  1 each  one-cycle grant pulses.
- disp_credit  out  8  frame-stable credit.
- disp_price  out  8  frame-stable price.
- flash_on  out  1  error-flash phase.
- busy  out  1  high when screen_mode != IDLE or any request is pending.

Function
REQ-006 SHALL latch each req_* into its own pending bit on any cycle. If a set and a clear of the same pending bit occur in the same cycle, the set SHALL win.
REQ-007 SHALL evaluate mode changes only on frame_tick cycles. Priority SHALL be ERROR > VEND > COIN.
REQ-008 IDLE with any pending bit set at frame_tick:
- enter the highest-priority mode;
- load the frame counter with that mode's FRAMES-1;
- clear that pending bit;
- pulse the matching ack_* in the next cycle.
REQ-009 In an active mode, each frame_tick SHALL decrement the counter by one.
REQ-010 When frame_tick arrives with the counter at 0, the block SHALL grant the highest pending request directly, per REQ-008. With nothing pending it SHALL return to IDLE.
REQ-011 Preemption: at frame_tick, a pending request of strictly higher priority than the active mode SHALL be granted immediately. The preempted screen SHALL be discarded, not resumed.
REQ-012 A pending request equal to the active mode SHALL, at frame_tick, reload the counter, clear the pending bit and pulse the ack.
REQ-013 A pending request of lower priority than the active mode SHALL stay pending until expiry.
REQ-014 On every frame_tick, disp_credit and disp_price SHALL load min(input, 99). Between ticks they SHALL hold their values.
REQ-015 Total latency from a request pulse to the screen_mode change SHALL be at most one frame plus one cycle. ack SHALL follow the screen_mode change by exactly one cycle.
REQ-016 The counter SHALL be wide enough for the largest FRAMES parameter and SHALL never wrap below 0.

Reset
REQ-017 While rst_n is low, the block SHALL hold these values:
- screen_mode = IDLE;
- counters = 0;
- pending bits = 0;
- ack_* = 0;
- disp_credit = 0, disp_price = 0;
- flash_on = 1;
- busy = 0.
REQ-018 Reset asserted mid-screen SHALL abort the screen immediately. No ack SHALL be issued during or after reset for requests made before reset.

Configuration
REQ-019 With macro VGA_SEQ_FLASH_EN defined:
- flash_on SHALL toggle every FLASH_FRAMES frame_ticks while in ERROR;
- flash_on SHALL be forced to 1 on ERROR entry and in every other mode.
REQ-020 Without VGA_SEQ_FLASH_EN, flash_on SHALL be constant 1 and no flash counter SHALL be synthesized.

Structure
REQ-021 Package vga_seq_pkg SHALL hold:
- the screen_mode encodings (IDLE/COIN/VEND/ERROR);
- the default frame-count constants;
- the value 99 as the display saturation limit.
REQ-022 The frame countdown SHALL be a sub-module named frame_timer (load, decrement on tick, zero flag). The flash counter SHALL reuse frame_timer.

Verification
REQ-023 Coin request: req_coin pulse in IDLE, COIN_FRAMES=3 -> screen_mode=1 at the next frame_tick, ack_coin one cycle later, IDLE on the 4th tick after entry.
REQ-024 Simultaneous requests: req_coin and req_error in the same cycle -> ERROR granted first; COIN granted at ERROR expiry with no IDLE gap.
REQ-025 Preemption: req_vend during COIN with counter=20 -> VEND at the next frame_tick; COIN is not resumed after VEND expires.
REQ-026 Saturation and frame stability: credit changes 5 -> 150 mid-frame -> disp_credit stays 5 until the next frame_tick, then becomes 99.
REQ-027 Reset mid-screen: rst_n low during VEND with req_coin pending -> all outputs at reset values; after release, no ack and screen_mode=0.
REQ-028 Flash: with VGA_SEQ_FLASH_EN and FLASH_FRAMES=2 in ERROR -> flash_on reads 1,1,0,0,1 over consecutive ticks. Without the macro, flash_on stays 1 throughout.
